// File: rtl/arm_id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_id_pkg
// Description : Shared encodings and helper functions for the ARM decode
//               stage: instruction mode, data-processing opcodes, EXE
//               command codes, condition codes, the decoded-control bundle,
//               and the decode_ctrl() / cond_check() functions.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_id_pkg;

    // Instruction class, instruction[27:26]
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // Data-processing opcodes, instruction[24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // ALU commands issued to EXE
    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    // Condition codes, instruction[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       s;
        logic       b;
    } ctrl_t;

    // Control decode from instruction class, opcode and S/L bit.
    function automatic ctrl_t decode_ctrl(input logic [1:0] mode,
                                          input logic [3:0] op,
                                          input logic       s_bit);
        ctrl_t c;
        c = '0;
        case (mode)
            MODE_DP: begin
                c.wb_en = 1'b1;
                c.s     = s_bit;
                case (op)
                    OP_MOV:  c.exe_cmd = EXE_MOV;
                    OP_MVN:  c.exe_cmd = EXE_MVN;
                    OP_ADD:  c.exe_cmd = EXE_ADD;
                    OP_ADC:  c.exe_cmd = EXE_ADC;
                    OP_SUB:  c.exe_cmd = EXE_SUB;
                    OP_SBC:  c.exe_cmd = EXE_SBC;
                    OP_AND:  c.exe_cmd = EXE_AND;
                    OP_ORR:  c.exe_cmd = EXE_ORR;
                    OP_EOR:  c.exe_cmd = EXE_EOR;
                    // Compares only update flags, never a register
                    OP_CMP: begin
                        c.exe_cmd = EXE_SUB;
                        c.wb_en   = 1'b0;
                        c.s       = 1'b1;
                    end
                    OP_TST: begin
                        c.exe_cmd = EXE_AND;
                        c.wb_en   = 1'b0;
                        c.s       = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            MODE_MEM: begin
                // Address is always base + offset
                c.exe_cmd = EXE_ADD;
                if (s_bit) begin
                    c.mem_r_en = 1'b1;
                    c.wb_en    = 1'b1;
                end else begin
                    c.mem_w_en = 1'b1;
                end
            end
            MODE_BR: c.b = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Condition evaluation against status {N,Z,C,V}; code 1111 never passes.
    function automatic logic cond_check(input logic [3:0] cond,
                                        input logic [3:0] sr);
        logic n, z, c, v, ok;
        {n, z, c, v} = sr;
        case (cond)
            COND_EQ: ok = z;
            COND_NE: ok = ~z;
            COND_CS: ok = c;
            COND_CC: ok = ~c;
            COND_MI: ok = n;
            COND_PL: ok = ~n;
            COND_VS: ok = v;
            COND_VC: ok = ~v;
            COND_HI: ok = c & ~z;
            COND_LS: ok = ~c | z;
            COND_GE: ok = (n == v);
            COND_LT: ok = (n != v);
            COND_GT: ok = ~z & (n == v);
            COND_LE: ok = z | (n != v);
            COND_AL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_bypass.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_bypass
// Description : REG_CNT x DATA_W register file, one write port, two
//               combinational read ports with write-through bypass so a
//               reader sees a same-cycle writeback. Cleared by the
//               asynchronous active-low rst.
// Ports       : clk, rst (active-low async)
//               i_we / i_waddr / i_wdata      - write port
//               i_raddr_1 / o_rdata_1         - read port 1
//               i_raddr_2 / o_rdata_2         - read port 2
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_bypass #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 16,
    parameter int AW      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr_1,
    input  logic [AW-1:0]     i_raddr_2,
    output logic [DATA_W-1:0] o_rdata_1,
    output logic [DATA_W-1:0] o_rdata_2
);

    logic [DATA_W-1:0] r_mem [REG_CNT];
    logic              w_hit_1;
    logic              w_hit_2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign w_hit_1   = i_we && (i_waddr == i_raddr_1);
    assign w_hit_2   = i_we && (i_waddr == i_raddr_2);
    assign o_rdata_1 = w_hit_1 ? i_wdata : r_mem[i_raddr_1];
    assign o_rdata_2 = w_hit_2 ? i_wdata : r_mem[i_raddr_2];

endmodule
`default_nettype wire

// File: rtl/id_stage_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_pipelined
// Description : ARM decode stage with integrated ID/EXE pipeline register.
//               Decodes the instruction, evaluates its condition, reads
//               operands from a bypassing register file and registers the
//               result for EXE. Supports stall (hold + operand refresh),
//               flush, hazard bubbles and a saturating bubble counter.
// Ports       : clk, rst (async active-low)
//               in_valid, instruction, pc_in     - from IF/ID
//               hazard, stall, flush, sr         - pipeline control / flags
//               wb_wb_en, wb_dest, wb_value      - writeback port
//               in_ready, src_1, src_2, two_src  - combinational to hazard unit
//               out_valid .. ex_src_2            - registered EXE entry
//               bubble_count                     - bubbles inserted since reset
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage_pipelined
    import arm_id_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int PC_W    = 32,
    parameter  int REG_CNT = 16,
    parameter  int CNT_W   = 16,
    localparam int REG_AW  = ($clog2(REG_CNT) < 4) ? 4 : $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              hazard,
    input  logic              stall,
    input  logic              flush,
    input  logic [3:0]        sr,
    input  logic              wb_wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic              in_ready,
    output logic [REG_AW-1:0] src_1,
    output logic [REG_AW-1:0] src_2,
    output logic              two_src,
    output logic              out_valid,
    output logic [3:0]        exe_cmd,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              wb_en,
    output logic              s,
    output logic              b,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] value_rn,
    output logic [DATA_W-1:0] value_rm,
    output logic [11:0]       shift_operand,
    output logic              imm,
    output logic [23:0]       imm_signed_24,
    output logic [REG_AW-1:0] dest,
    output logic [REG_AW-1:0] ex_src_1,
    output logic [REG_AW-1:0] ex_src_2,
    output logic [CNT_W-1:0]  bubble_count
);

    ctrl_t             w_ctrl_dec;
    ctrl_t             w_ctrl_ld;
    logic              w_cond_ok;
    logic              w_kill;
    logic              w_load;
    logic              w_bubble;
    logic [DATA_W-1:0] w_rdata_1;
    logic [DATA_W-1:0] w_rdata_2;

    // ------------------------------------------------------------------
    // Decode and condition
    // ------------------------------------------------------------------
    assign w_ctrl_dec = decode_ctrl(instruction[27:26], instruction[24:21], instruction[20]);
    assign w_cond_ok  = cond_check(instruction[31:28], sr);
    assign w_kill     = ~in_valid | hazard | ~w_cond_ok;

    always_comb begin
        w_ctrl_ld = w_ctrl_dec;
        if (w_kill) begin
            w_ctrl_ld = '0;
        end
    end

    // A store reads rd as its data operand, so port 2 switches to rd.
    assign src_1    = REG_AW'(instruction[19:16]);
    assign src_2    = w_ctrl_dec.mem_w_en ? REG_AW'(instruction[15:12])
                                          : REG_AW'(instruction[3:0]);
    assign two_src  = ~instruction[25] | w_ctrl_dec.mem_w_en;
    assign in_ready = ~stall & ~hazard;

    assign w_load   = ~flush & ~stall;
    assign w_bubble = in_valid & (hazard | ~w_cond_ok);

    // ------------------------------------------------------------------
    // Operand register file
    // ------------------------------------------------------------------
    reg_file_bypass #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT),
        .AW      (REG_AW)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .i_we      (wb_wb_en),
        .i_waddr   (wb_dest),
        .i_wdata   (wb_value),
        .i_raddr_1 (src_1),
        .i_raddr_2 (src_2),
        .o_rdata_1 (w_rdata_1),
        .o_rdata_2 (w_rdata_2)
    );

    // ------------------------------------------------------------------
    // ID/EXE pipeline register: flush > stall > load
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            exe_cmd       <= '0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            wb_en         <= 1'b0;
            s             <= 1'b0;
            b             <= 1'b0;
            pc_out        <= '0;
            value_rn      <= '0;
            value_rm      <= '0;
            shift_operand <= '0;
            imm           <= 1'b0;
            imm_signed_24 <= '0;
            dest          <= '0;
            ex_src_1      <= '0;
            ex_src_2      <= '0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            exe_cmd       <= '0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            wb_en         <= 1'b0;
            s             <= 1'b0;
            b             <= 1'b0;
            pc_out        <= '0;
            value_rn      <= '0;
            value_rm      <= '0;
            shift_operand <= '0;
            imm           <= 1'b0;
            imm_signed_24 <= '0;
            dest          <= '0;
            ex_src_1      <= '0;
            ex_src_2      <= '0;
        end else if (stall) begin
            // Held entry must not go stale while a writeback lands on its sources
            if (wb_wb_en && (wb_dest == ex_src_1)) begin
                value_rn <= wb_value;
            end
            if (wb_wb_en && (wb_dest == ex_src_2)) begin
                value_rm <= wb_value;
            end
        end else begin
            out_valid     <= in_valid & ~hazard;
            exe_cmd       <= w_ctrl_ld.exe_cmd;
            mem_r_en      <= w_ctrl_ld.mem_r_en;
            mem_w_en      <= w_ctrl_ld.mem_w_en;
            wb_en         <= w_ctrl_ld.wb_en;
            s             <= w_ctrl_ld.s;
            b             <= w_ctrl_ld.b;
            pc_out        <= pc_in;
            value_rn      <= w_rdata_1;
            value_rm      <= w_rdata_2;
            shift_operand <= instruction[11:0];
            imm           <= instruction[25];
            imm_signed_24 <= instruction[23:0];
            dest          <= REG_AW'(instruction[15:12]);
            ex_src_1      <= src_1;
            ex_src_2      <= src_2;
        end
    end

    // ------------------------------------------------------------------
    // Saturating bubble counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_count <= '0;
        end else if (w_load && w_bubble && (bubble_count != {CNT_W{1'b1}})) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage_pipelined
// Description : Self-checking bench for id_stage_pipelined. Directed steps
//               followed by randomized traffic, all checked against a
//               behavioural model of the decode stage kept in this file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage_pipelined;

    localparam int CW = 4;   // narrow counter so saturation is reachable

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        hazard, stall, flush;
    logic [3:0]  sr;
    logic        wb_wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        in_ready, two_src, out_valid;
    logic [3:0]  src_1, src_2, exe_cmd;
    logic        mem_r_en, mem_w_en, wb_en, s, b, imm;
    logic [31:0] pc_out, value_rn, value_rm;
    logic [11:0] shift_operand;
    logic [23:0] imm_signed_24;
    logic [3:0]  dest, ex_src_1, ex_src_2;
    logic [CW-1:0] bubble_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_stage_pipelined #(
        .DATA_W(32), .PC_W(32), .REG_CNT(16), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .pc_in(pc_in), .hazard(hazard), .stall(stall), .flush(flush), .sr(sr),
        .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .in_ready(in_ready), .src_1(src_1), .src_2(src_2), .two_src(two_src),
        .out_valid(out_valid), .exe_cmd(exe_cmd), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .wb_en(wb_en), .s(s), .b(b), .pc_out(pc_out),
        .value_rn(value_rn), .value_rm(value_rm), .shift_operand(shift_operand),
        .imm(imm), .imm_signed_24(imm_signed_24), .dest(dest),
        .ex_src_1(ex_src_1), .ex_src_2(ex_src_2), .bubble_count(bubble_count)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_rf [16];
    logic        m_valid;
    logic [8:0]  m_ctrl;     // {exe_cmd, mem_r_en, mem_w_en, wb_en, s, b}
    logic [31:0] m_pc, m_rn, m_rm;
    logic [11:0] m_shift;
    logic        m_imm;
    logic [23:0] m_imm24;
    logic [3:0]  m_dest, m_s1, m_s2;
    int          m_bub;

    function automatic logic [8:0] ref_ctrl(input logic [31:0] ins);
        logic [3:0] op;
        logic [3:0] cmd;
        logic       sb;
        logic [8:0] r;
        op = ins[24:21];
        sb = ins[20];
        r  = '0;
        if (ins[27:26] == 2'b00) begin
            case (op)
                4'b1101: cmd = 4'd1;   // MOV
                4'b1111: cmd = 4'd9;   // MVN
                4'b0100: cmd = 4'd2;   // ADD
                4'b0101: cmd = 4'd3;   // ADC
                4'b0010: cmd = 4'd4;   // SUB
                4'b0110: cmd = 4'd5;   // SBC
                4'b0000: cmd = 4'd6;   // AND
                4'b1100: cmd = 4'd7;   // ORR
                4'b0001: cmd = 4'd8;   // EOR
                4'b1010: cmd = 4'd4;   // CMP
                4'b1000: cmd = 4'd6;   // TST
                default: cmd = 4'd0;
            endcase
            if (op == 4'b1010 || op == 4'b1000) r = {cmd, 5'b00010};
            else if (cmd != 4'd0)                r = {cmd, 3'b001, sb, 1'b0};
        end else if (ins[27:26] == 2'b01) begin
            r = sb ? {4'd2, 5'b10100} : {4'd2, 5'b01000};
        end else if (ins[27:26] == 2'b10) begin
            r = 9'd1;
        end
        return r;
    endfunction

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rf_read(input logic [3:0] a);
        return (wb_wb_en && wb_dest == a) ? wb_value : m_rf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_valid = 0; m_ctrl = '0; m_pc = '0; m_rn = '0; m_rm = '0;
        m_shift = '0; m_imm = 0; m_imm24 = '0; m_dest = '0; m_s1 = '0; m_s2 = '0;
        m_bub = 0;
    endtask

    task automatic model_edge();
        logic       ok;
        logic [8:0] c;
        ok = ref_cond(instruction[31:28], sr);
        c  = ref_ctrl(instruction);
        if (flush) begin
            m_valid = 0; m_ctrl = '0; m_pc = '0; m_rn = '0; m_rm = '0;
            m_shift = '0; m_imm = 0; m_imm24 = '0; m_dest = '0; m_s1 = '0; m_s2 = '0;
        end else if (stall) begin
            if (wb_wb_en && wb_dest == m_s1) m_rn = wb_value;
            if (wb_wb_en && wb_dest == m_s2) m_rm = wb_value;
        end else begin
            m_valid = in_valid && !hazard;
            m_ctrl  = (in_valid && !hazard && ok) ? c : 9'd0;
            m_pc    = pc_in;
            m_s1    = instruction[19:16];
            m_s2    = c[3] ? instruction[15:12] : instruction[3:0];
            m_rn    = rf_read(m_s1);
            m_rm    = rf_read(m_s2);
            m_shift = instruction[11:0];
            m_imm   = instruction[25];
            m_imm24 = instruction[23:0];
            m_dest  = instruction[15:12];
            if (in_valid && (hazard || !ok) && m_bub < (2**CW - 1)) m_bub++;
        end
        if (wb_wb_en) m_rf[wb_dest] = wb_value;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_comb();
        logic [8:0] c;
        c = ref_ctrl(instruction);
        chk("src_1", src_1, instruction[19:16]);
        chk("src_2", src_2, c[3] ? instruction[15:12] : instruction[3:0]);
        chk("two_src", two_src, !instruction[25] || c[3]);
        chk("in_ready", in_ready, !stall && !hazard);
    endtask

    task automatic check_regs();
        chk("out_valid", out_valid, m_valid);
        chk("ctrl", {exe_cmd, mem_r_en, mem_w_en, wb_en, s, b}, m_ctrl);
        chk("pc_out", pc_out, m_pc);
        chk("value_rn", value_rn, m_rn);
        chk("value_rm", value_rm, m_rm);
        chk("fields", {shift_operand, imm, imm_signed_24, dest, ex_src_1, ex_src_2},
            {m_shift, m_imm, m_imm24, m_dest, m_s1, m_s2});
        chk("bubble_count", bubble_count, 64'(m_bub));
    endtask

    task automatic cycle();
        #1;
        check_comb();
        model_edge();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle();
        in_valid = 0; instruction = '0; pc_in = '0; hazard = 0; stall = 0;
        flush = 0; sr = '0; wb_wb_en = 0; wb_dest = '0; wb_value = '0;
    endtask

    task automatic rand_inputs();
        logic [31:0] ins;
        ins = $urandom;
        if ($urandom_range(0, 9) < 6) ins[31:28] = 4'hE;
        if ($urandom_range(0, 3) == 0) ins[27:26] = 2'b01;
        instruction = ins;
        in_valid = ($urandom_range(0, 9) < 8);
        hazard   = ($urandom_range(0, 5) == 0);
        stall    = ($urandom_range(0, 4) == 0);
        flush    = ($urandom_range(0, 9) == 0);
        sr       = 4'($urandom);
        pc_in    = $urandom;
        wb_wb_en = 1'($urandom);
        wb_dest  = 4'($urandom);
        wb_value = $urandom;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("reset_out_valid", out_valid, 0);
        rst = 1'b1;

        // preload r2=5, r3=7
        wb_wb_en = 1; wb_dest = 4'd2; wb_value = 32'd5; cycle();
        wb_dest = 4'd3; wb_value = 32'd7; cycle();
        wb_wb_en = 0;

        // ADD r1,r2,r3
        instruction = 32'hE0821003; in_valid = 1; pc_in = 32'h104; sr = 4'b0000;
        cycle();
        chk("add_exe_cmd", exe_cmd, 4'b0010);
        chk("add_wb_en", wb_en, 1);
        chk("add_value_rn", value_rn, 5);
        chk("add_value_rm", value_rm, 7);
        chk("add_dest", dest, 1);
        chk("add_out_valid", out_valid, 1);

        // ADDEQ with Z clear: valid entry, zero controls, one bubble
        instruction = 32'h00821003;
        cycle();
        chk("addeq_out_valid", out_valid, 1);
        chk("addeq_ctrl", {exe_cmd, mem_r_en, mem_w_en, wb_en, s, b}, 0);
        chk("addeq_bubbles", bubble_count, 1);

        // hazard on a valid MOV
        instruction = 32'hE3A01005; hazard = 1;
        #1 chk("hazard_in_ready", in_ready, 0);
        cycle();
        chk("hazard_out_valid", out_valid, 0);
        chk("hazard_bubbles", bubble_count, 2);
        stall = 1;
        cycle();
        chk("hz_stall_bubbles", bubble_count, 2);
        chk("hz_stall_out_valid", out_valid, 0);
        hazard = 0; stall = 0;

        // stall for 3 cycles with a writeback to r2 in the middle
        instruction = 32'hE0821003; cycle();
        stall = 1; instruction = 32'hE0454006;
        cycle();
        chk("stall1_value_rn", value_rn, 5);
        wb_wb_en = 1; wb_dest = 4'd2; wb_value = 32'd9;
        cycle();
        chk("stall2_value_rn", value_rn, 9);
        chk("stall2_exe_cmd", exe_cmd, 4'b0010);
        chk("stall2_dest", dest, 1);
        wb_wb_en = 0;
        cycle();
        chk("stall3_value_rn", value_rn, 9);
        stall = 0;
        cycle();
        chk("unstall_exe_cmd", exe_cmd, 4'b0100);
        chk("unstall_dest", dest, 4);

        // STR r3,[r4] with same-cycle writeback of r3
        instruction = 32'hE5843000; wb_wb_en = 1; wb_dest = 4'd3; wb_value = 32'hDEAD;
        #1;
        chk("str_src_2", src_2, 3);
        chk("str_two_src", two_src, 1);
        cycle();
        chk("str_value_rm", value_rm, 32'hDEAD);
        chk("str_mem_w_en", mem_w_en, 1);
        wb_wb_en = 0;

        // flush wins over stall
        instruction = 32'hE0821003; flush = 1; stall = 1;
        cycle();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_ctrl", {exe_cmd, mem_r_en, mem_w_en, wb_en, s, b}, 0);
        flush = 0; stall = 0;

        // drive the counter into saturation
        instruction = 32'h00821003; sr = 4'b0000;
        repeat (16) cycle();
        chk("bubble_saturate", bubble_count, {CW{1'b1}});

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            cycle();
        end

        // asynchronous reset between clock edges
        idle();
        instruction = 32'hE0821003; in_valid = 1;
        #2 rst = 1'b0;
        #1;
        chk("areset_out_valid", out_valid, 0);
        chk("areset_ctrl", {exe_cmd, mem_r_en, mem_w_en, wb_en, s, b}, 0);
        chk("areset_data", {pc_out, value_rn, value_rm}, 0);
        chk("areset_bubbles", bubble_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_regs();
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
